// File: rtl/note_scroller_pkg.sv
// Shared types for the note scroller: lane codes, slot record, FSM states.
package note_pkg;
  localparam logic [1:0] LANE_RIGHT = 2'd0;
  localparam logic [1:0] LANE_UP    = 2'd1;
  localparam logic [1:0] LANE_DOWN  = 2'd2;
  localparam logic [1:0] LANE_LEFT  = 2'd3;

  localparam int SLOT_Y_W = 11;

  typedef struct packed {
    logic                active;
    logic [1:0]          lane;
    logic [SLOT_Y_W-1:0] y;
  } slot_t;

  typedef enum logic {IDLE, SWEEP} state_t;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/note_scroller_if.sv
// Spawn, button, slot-bus and scoring signals between game logic and note scroller.
interface note_scroller_if #(
  parameter int NUM_SLOTS = 8,
  parameter int Y_WIDTH   = 11
);
  logic                         vga_vs;
  logic                         spawn_valid;
  logic [1:0]                   spawn_lane;
  logic                         spawn_ready;
  logic [3:0]                   btn;
  logic [NUM_SLOTS-1:0]         slot_active;
  logic [2*NUM_SLOTS-1:0]       slot_lane;
  logic [Y_WIDTH*NUM_SLOTS-1:0] slot_y;
  logic [3:0]                   hit;
  logic [3:0]                   miss;
  logic [15:0]                  score;
  logic [7:0]                   combo;

  modport master (
    output vga_vs, spawn_valid, spawn_lane, btn,
    input  spawn_ready, slot_active, slot_lane, slot_y, hit, miss, score, combo
  );
  modport slave (
    input  vga_vs, spawn_valid, spawn_lane, btn,
    output spawn_ready, slot_active, slot_lane, slot_y, hit, miss, score, combo
  );
endinterface

// File: rtl/note_scroller_lane_judge.sv
// Per-lane hit search: lowest-index active slot of this lane inside the target window.
module lane_judge import note_pkg::*; #(
  parameter int NUM_SLOTS  = 8,
  parameter int Y_WIDTH    = 11,
  parameter int TARGET_Y   = 36,
  parameter int HIT_WINDOW = 12,
  localparam int IDX_W     = $clog2(NUM_SLOTS)
)(
  input  logic [1:0]                          i_lane,
  input  logic [NUM_SLOTS-1:0]                i_active,
  input  logic [NUM_SLOTS-1:0][1:0]           i_lanes,
  input  logic [NUM_SLOTS-1:0][Y_WIDTH-1:0]   i_y,
  output logic                                o_found,
  output logic [IDX_W-1:0]                    o_idx
);
  logic [NUM_SLOTS-1:0] w_match;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      w_match[i] = i_active[i] && (i_lanes[i] == i_lane) &&
                   (int'(i_y[i]) + HIT_WINDOW >= TARGET_Y) &&
                   (int'(i_y[i]) <= TARGET_Y + HIT_WINDOW);
    // walk downward so the lowest matching index wins
    for (int i = NUM_SLOTS-1; i >= 0; i--)
      if (w_match[i]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(i);
      end
  end
endmodule

// File: rtl/note_scroller.sv
// Note slot store: spawns notes, scrolls them once per frame, judges presses, keeps score.
module note_scroller import note_pkg::*; #(
  parameter int NUM_SLOTS  = 8,
  parameter int Y_WIDTH    = SLOT_Y_W,
  parameter int SPAWN_Y    = 480,
  parameter int TARGET_Y   = 36,
  parameter int SPEED      = 2,
  parameter int HIT_WINDOW = 12
)(
  input logic            clk,
  input logic            iRST_N,
  note_scroller_if.slave bus
);
  localparam int IDX_W    = $clog2(NUM_SLOTS);
  localparam int RETIRE_Y = TARGET_Y - HIT_WINDOW + SPEED;

  state_t                        r_state;
  logic [IDX_W-1:0]              r_idx;
  slot_t [NUM_SLOTS-1:0]         r_slot;
  logic                          r_vs_d1, r_vs_d2, r_run;
  logic [3:0]                    r_pend, r_hit, r_miss;
  logic [15:0]                   r_score;
  logic [7:0]                    r_combo;

  logic [NUM_SLOTS-1:0]              w_act;
  logic [NUM_SLOTS-1:0][1:0]         w_lanes;
  logic [NUM_SLOTS-1:0][Y_WIDTH-1:0] w_ys;
  logic [3:0]                        w_press, w_found, w_hit;
  logic [3:0][IDX_W-1:0]             w_jidx;
  logic                              w_tick, w_ready, w_accept, w_free_ok;
  logic [IDX_W-1:0]                  w_free_idx;
  logic [16:0]                       w_score_sum;
  logic [8:0]                        w_combo_sum;
  slot_t                             w_cur;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign w_act[gi]   = r_slot[gi].active;
      assign w_lanes[gi] = r_slot[gi].lane;
      assign w_ys[gi]    = r_slot[gi].y;
      assign bus.slot_active[gi]                 = r_slot[gi].active;
      assign bus.slot_lane[2*gi +: 2]            = r_slot[gi].lane;
      assign bus.slot_y[Y_WIDTH*gi +: Y_WIDTH]   = r_slot[gi].y;
    end
    for (gi = 0; gi < 4; gi++) begin : g_lane
      lane_judge #(
        .NUM_SLOTS(NUM_SLOTS), .Y_WIDTH(Y_WIDTH),
        .TARGET_Y(TARGET_Y), .HIT_WINDOW(HIT_WINDOW)
      ) u_judge (
        .i_lane(2'(gi)), .i_active(w_act), .i_lanes(w_lanes), .i_y(w_ys),
        .o_found(w_found[gi]), .o_idx(w_jidx[gi])
      );
    end
  endgenerate

  assign w_tick    = r_vs_d2 & ~r_vs_d1;
  assign w_press   = (r_state == IDLE) ? (bus.btn | r_pend) : 4'd0;
  assign w_hit     = w_press & w_found;
  assign w_free_ok = ~&w_act;
  assign w_ready   = r_run && (r_state == IDLE) && w_free_ok;
  assign w_accept  = bus.spawn_valid && w_ready;
  assign w_cur     = r_slot[r_idx];
  assign w_score_sum = {1'b0, r_score} + {14'd0, popcnt4(w_hit)};
  assign w_combo_sum = {1'b0, r_combo} + {6'd0, popcnt4(w_hit)};

  // free slot comes from registered state, so a slot freed by this cycle's hit is never reused
  always_comb begin
    w_free_idx = '0;
    for (int i = NUM_SLOTS-1; i >= 0; i--)
      if (!w_act[i]) w_free_idx = IDX_W'(i);
  end

  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_slot  <= '0;
      r_vs_d1 <= 1'b0;
      r_vs_d2 <= 1'b0;
      r_run   <= 1'b0;
      r_pend  <= '0;
      r_hit   <= '0;
      r_miss  <= '0;
      r_score <= '0;
      r_combo <= '0;
    end else begin
      r_vs_d1 <= bus.vga_vs;
      r_vs_d2 <= r_vs_d1;
      r_run   <= 1'b1;
      r_hit   <= w_hit;
      r_miss  <= '0;
      case (r_state)
        IDLE: begin
          r_pend <= '0;
          for (int l = 0; l < 4; l++)
            if (w_hit[l]) r_slot[w_jidx[l]].active <= 1'b0;
          if (|w_hit) begin
            r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
            r_combo <= w_combo_sum[8]  ? 8'hFF    : w_combo_sum[7:0];
          end
          if (w_accept)
            r_slot[w_free_idx] <= '{active: 1'b1, lane: bus.spawn_lane,
                                    y: SLOT_Y_W'(SPAWN_Y)};
          if (w_tick) begin
            r_state <= SWEEP;
            r_idx   <= '0;
          end
        end
        SWEEP: begin
          r_pend <= r_pend | bus.btn;
          if (w_cur.active) begin
            if (int'(w_cur.y) < RETIRE_Y) begin
              r_slot[r_idx].active <= 1'b0;
              r_miss[w_cur.lane]   <= 1'b1;
              r_combo              <= '0;
            end else begin
              r_slot[r_idx].y <= w_cur.y - SLOT_Y_W'(SPEED);
            end
          end
          if (r_idx == IDX_W'(NUM_SLOTS-1)) r_state <= IDLE;
          r_idx <= r_idx + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.spawn_ready = w_ready;
  assign bus.hit         = r_hit;
  assign bus.miss        = r_miss;
  assign bus.score       = r_score;
  assign bus.combo       = r_combo;
endmodule

// File: tb/tb_note_scroller.sv
// Directed bench for note_scroller: vector tables for spawn/judge plus frame-level sequences.
module tb_note_scroller;
  import note_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   low_cnt;
  logic [3:0] miss_acc;

  always #5 clk = ~clk;

  note_scroller_if #(.NUM_SLOTS(8), .Y_WIDTH(11)) bus();

  note_scroller #(
    .NUM_SLOTS(8), .Y_WIDTH(11), .SPAWN_Y(480), .TARGET_Y(36),
    .SPEED(2), .HIT_WINDOW(12)
  ) dut (.clk(clk), .iRST_N(rst_n), .bus(bus.slave));

  typedef struct {
    logic       sv;
    logic [1:0] sl;
    logic [3:0] btn;
    logic       ready;
    logic [7:0] act;
    logic [3:0] hit;
    logic [15:0] score;
    logic [7:0] combo;
  } vec_t;

  vec_t fillv[9];
  vec_t judgev[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [10:0] ys(input int i);
    logic [87:0] v;
    v = bus.slot_y;
    return v[11*i +: 11];
  endfunction

  function automatic logic [1:0] ln(input int i);
    logic [15:0] v;
    v = bus.slot_lane;
    return v[2*i +: 2];
  endfunction

  task automatic frame();
    bus.vga_vs = 1'b0;
    step();
    bus.vga_vs = 1'b1;
    step();
    low_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      miss_acc = miss_acc | bus.miss;
      if (!bus.spawn_ready) low_cnt++;
      step();
    end
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame();
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    bus.spawn_valid = v.sv;
    bus.spawn_lane  = v.sl;
    bus.btn         = v.btn;
    step();
    bus.spawn_valid = 1'b0;
    bus.btn         = 4'd0;
    chk({tag, ".ready"}, 32'(bus.spawn_ready), 32'(v.ready));
    chk({tag, ".active"}, 32'(bus.slot_active), 32'(v.act));
    chk({tag, ".hit"}, 32'(bus.hit), 32'(v.hit));
    chk({tag, ".score"}, 32'(bus.score), 32'(v.score));
    chk({tag, ".combo"}, 32'(bus.combo), 32'(v.combo));
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".active"}, 32'(bus.slot_active), 32'd0);
    chk({tag, ".lane"}, 32'(bus.slot_lane), 32'd0);
    chk({tag, ".y_or"}, 32'(|bus.slot_y), 32'd0);
    chk({tag, ".hitmiss"}, 32'({bus.hit, bus.miss}), 32'd0);
    chk({tag, ".score"}, 32'(bus.score), 32'd0);
    chk({tag, ".combo"}, 32'(bus.combo), 32'd0);
    chk({tag, ".ready"}, 32'(bus.spawn_ready), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      fillv[i] = '{sv: 1'b1, sl: 2'(i % 4), btn: 4'd0, ready: (i < 7),
                   act: 8'((1 << (i + 1)) - 1), hit: 4'd0, score: 16'd1, combo: 8'd0};
    fillv[8]  = '{1'b1, LANE_RIGHT, 4'd0,    1'b0, 8'hFF, 4'd0,    16'd1, 8'd0};
    judgev[0] = '{1'b1, LANE_LEFT,  4'b0010, 1'b1, 8'hFD, 4'b0010, 16'd2, 8'd1};
    judgev[1] = '{1'b1, LANE_LEFT,  4'b0000, 1'b0, 8'hFF, 4'b0000, 16'd2, 8'd1};
    judgev[2] = '{1'b0, LANE_RIGHT, 4'b0101, 1'b1, 8'hFA, 4'b0101, 16'd4, 8'd3};
    judgev[3] = '{1'b0, LANE_RIGHT, 4'b1000, 1'b1, 8'hF2, 4'b1000, 16'd5, 8'd4};
    judgev[4] = '{1'b0, LANE_RIGHT, 4'b0010, 1'b1, 8'hD2, 4'b0010, 16'd6, 8'd5};
    judgev[5] = '{1'b0, LANE_RIGHT, 4'b0010, 1'b1, 8'hD2, 4'b0000, 16'd6, 8'd5};

    bus.vga_vs = 1'b1; bus.spawn_valid = 1'b0; bus.spawn_lane = 2'd0; bus.btn = 4'd0;
    miss_acc = 4'd0;
    @(negedge clk); @(negedge clk);
    all_zero("reset");
    rst_n = 1'b1;
    step();
    chk("ready_after_release", 32'(bus.spawn_ready), 32'd1);

    // spawn lane 2, one cycle to slot outputs
    bus.spawn_valid = 1'b1; bus.spawn_lane = LANE_DOWN;
    step();
    bus.spawn_valid = 1'b0;
    chk("spawn.active", 32'(bus.slot_active), 32'h01);
    chk("spawn.lane", 32'(ln(0)), 32'd2);
    chk("spawn.y", 32'(ys(0)), 32'd480);
    chk("spawn.ready", 32'(bus.spawn_ready), 32'd1);

    frame();
    chk("sweep.low_cycles", 32'(low_cnt), 32'd8);
    chk("sweep.y", 32'(ys(0)), 32'd478);

    frames(219);
    chk("approach.y", 32'(ys(0)), 32'd40);
    bus.btn = 4'b0100;
    step();
    bus.btn = 4'd0;
    chk("hit.pulse", 32'(bus.hit), 32'b0100);
    chk("hit.active", 32'(bus.slot_active), 32'h00);
    chk("hit.score", 32'(bus.score), 32'd1);
    chk("hit.combo", 32'(bus.combo), 32'd1);
    step();
    chk("hit.one_cycle", 32'(bus.hit), 32'd0);

    // lane-0 note passes unpressed
    bus.spawn_valid = 1'b1; bus.spawn_lane = LANE_RIGHT;
    step();
    bus.spawn_valid = 1'b0;
    miss_acc = 4'd0;
    frames(228);
    chk("pass.y24", 32'(ys(0)), 32'd24);
    chk("pass.no_early_miss", 32'(miss_acc), 32'd0);
    frame();
    chk("pass.miss", 32'(miss_acc), 32'b0001);
    chk("pass.active", 32'(bus.slot_active), 32'h00);
    chk("pass.combo", 32'(bus.combo), 32'd0);
    chk("pass.score", 32'(bus.score), 32'd1);

    for (int i = 0; i < 9; i++) apply_vec($sformatf("fill%0d", i), fillv[i]);
    frames(220);
    chk("full.y0", 32'(ys(0)), 32'd40);
    chk("full.y7", 32'(ys(7)), 32'd40);
    for (int i = 0; i < 6; i++) apply_vec($sformatf("judge%0d", i), judgev[i]);
    chk("respawn.lane", 32'(ln(1)), 32'd3);
    chk("respawn.y", 32'(ys(1)), 32'd480);

    // press during sweep is held and judged on the first idle cycle
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bus.spawn_valid = 1'b1; bus.spawn_lane = LANE_UP;
    step();
    bus.spawn_valid = 1'b0;
    frames(221);
    chk("pend.y38", 32'(ys(0)), 32'd38);
    bus.vga_vs = 1'b0;
    step();
    bus.vga_vs = 1'b1;
    step();
    bus.btn = 4'b0010;
    step();
    bus.btn = 4'd0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("pend.nohit%0d", k), 32'(bus.hit), 32'd0);
      step();
    end
    chk("pend.y36", 32'(ys(0)), 32'd36);
    chk("pend.idle_nohit", 32'(bus.hit), 32'd0);
    step();
    chk("pend.hit", 32'(bus.hit), 32'b0010);
    chk("pend.score", 32'(bus.score), 32'd1);

    // asynchronous reset in the middle of a sweep
    bus.spawn_valid = 1'b1; bus.spawn_lane = LANE_DOWN;
    step();
    bus.spawn_valid = 1'b0;
    bus.vga_vs = 1'b0;
    step();
    bus.vga_vs = 1'b1;
    step(); step(); step();
    chk("midsweep.busy", 32'(bus.spawn_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("midreset.ready", 32'(bus.spawn_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
